// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register dump reader.
package reg_dump_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD,
    FIN
  } dumpState_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Bus bundle for the dump reader: control, storage read port and output stream.
// slave = dump reader side, master = surrounding system / bench side.
interface reg_dump_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  out_parity;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, start_addr, count, rd_data, out_ready,
    output rd_en, rd_addr, out_data, out_valid, out_last, out_parity, busy, done
  );

  modport master (
    output start, start_addr, count, rd_data, out_ready,
    input  rd_en, rd_addr, out_data, out_valid, out_last, out_parity, busy, done
  );
endinterface

// File: rtl/reg_dump_out_stage.sv
// Output register stage of the dump stream. Owns out_data/valid/last/parity so the
// "stable while valid && !ready" rule lives in exactly one place.
// Optional: REG_DUMP_PARITY_EN registers even parity of the word alongside it.
module reg_dump_out_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic                  loadLast,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  output logic                  outLast,
  output logic                  outParity
);

  // Load a fresh word, or drop valid/last once the consumer takes it; data is held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outData  <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end else if (load) begin
      outData  <= loadData;
      outValid <= 1'b1;
      outLast  <= loadLast;
    end else if (outValid && ready) begin
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end
  end

`ifdef REG_DUMP_PARITY_EN
  // Parity is captured with the word so it cannot change while the word is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    outParity <= 1'b0;
    else if (load) outParity <= ^loadData;
  end
`else
  assign outParity = 1'b0;
`endif

endmodule

// File: rtl/reg_dump_reader.sv
// Sequential register dump: reads count words from start_addr (wrapping at NUM_REGS)
// through a 1-cycle-latency read port and streams them out with valid/ready.
// One read outstanding at a time; 3 cycles per word with ready held high.
// Build option: REG_DUMP_PARITY_EN enables out_parity (tied low otherwise).
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic            clk,
  input logic            reset,
  reg_dump_reader_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  dumpState_e            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic [CNT_W-1:0]      remaining;
  logic [CNT_W-1:0]      countClamp;
  logic                  rdEn;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic                  doneQ;
  logic [DATA_WIDTH-1:0] outData;
  logic                  outValid;
  logic                  outLast;
  logic                  outParity;

  assign countClamp = (bus.count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : bus.count;
  assign nextAddr   = (addr == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : addr + 1'b1;

  // Dump sequencer: rd_en/rd_addr/done are set on the edge entering ISSUE/FIN so they
  // are registered and line up exactly with those states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      rdEn      <= 1'b0;
      rdAddr    <= '0;
      doneQ     <= 1'b0;
    end else begin
      rdEn  <= 1'b0;
      doneQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              addr      <= bus.start_addr;
              remaining <= countClamp;
              rdEn      <= 1'b1;
              rdAddr    <= bus.start_addr;
              state     <= ISSUE;
            end else begin
              doneQ <= 1'b1;
              state <= FIN;
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          remaining <= remaining - 1'b1;
          addr      <= nextAddr;
          state     <= HOLD;
        end
        HOLD: begin
          if (outValid && bus.out_ready) begin
            if (remaining != '0) begin
              rdEn   <= 1'b1;
              rdAddr <= addr;
              state  <= ISSUE;
            end else begin
              doneQ <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  reg_dump_out_stage #(.DATA_WIDTH(DATA_WIDTH)) uOut (
    .clk      (clk),
    .reset    (reset),
    .load     (state == CAPTURE),
    .loadData (bus.rd_data),
    .loadLast (remaining == CNT_W'(1)),
    .ready    (bus.out_ready),
    .outData  (outData),
    .outValid (outValid),
    .outLast  (outLast),
    .outParity(outParity)
  );

  assign bus.rd_en      = rdEn;
  assign bus.rd_addr    = rdAddr;
  assign bus.out_data   = outData;
  assign bus.out_valid  = outValid;
  assign bus.out_last   = outLast;
  assign bus.out_parity = outParity;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = doneQ;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench for reg_dump_reader. The reference model expands
// each accepted dump into queues of expected read addresses and beats.
module tb_reg_dump_reader;
  localparam int NUM = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_dump_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_dump_reader dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem [NUM];
  int total = 0;
  int bad = 0;
  int doneCnt = 0;
  int dumpBase = 0;
  int rdyMode = 0;  // 0: ready high, 1: random, 2: manual
  int expAddr[$];
  logic [31:0] expData[$];
  bit expLast[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic parOf(input logic [31:0] d);
`ifdef REG_DUMP_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // storage: data valid the cycle after the strobe
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  // consumer ready driver
  initial forever begin
    @(posedge clk); #1;
    if (rdyMode == 0) bus.out_ready = 1'b1;
    else if (rdyMode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: reads and beats against the model queues
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (bus.done) doneCnt++;
      if (bus.rd_en) begin
        chk("rdOverlap", bus.out_valid, 0);
        chk("rdBusy", bus.busy, 1);
        if (expAddr.size() == 0) chk("unexpRd", 1, 0);
        else chk("rdAddr", bus.rd_addr, expAddr.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expData.size() == 0) chk("unexpBeat", 1, 0);
        else begin
          logic [31:0] d;
          bit l;
          d = expData.pop_front();
          l = expLast.pop_front();
          chk("data", bus.out_data, d);
          chk("last", bus.out_last, l);
          chk("parity", bus.out_parity, parOf(d));
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    chk({tag, ".rd_en"}, bus.rd_en, 0);
    chk({tag, ".rd_addr"}, bus.rd_addr, 0);
    chk({tag, ".out_data"}, bus.out_data, 0);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".out_last"}, bus.out_last, 0);
    chk({tag, ".out_parity"}, bus.out_parity, 0);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".done"}, bus.done, 0);
  endtask

  task automatic runDump(input int sa, input int cnt);
    int n;
    n = (cnt > NUM) ? NUM : cnt;
    for (int i = 0; i < n; i++) begin
      expAddr.push_back((sa + i) % NUM);
      expData.push_back(mem[(sa + i) % NUM]);
      expLast.push_back(i == n - 1);
    end
    dumpBase = doneCnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.start_addr = 5'(sa);
    bus.count = 6'(cnt);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int k = 0; k < 1000 && doneCnt == dumpBase; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk({tag, ".doneCnt"}, doneCnt - dumpBase, 1);
    chk({tag, ".leftover"}, expAddr.size() + expData.size(), 0);
    chk({tag, ".idle"}, bus.busy, 0);
  endtask

  task automatic waitValid(input string tag);
    int k;
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".validSeen"}, bus.out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0;
    logic l0;
    int doneAt;
    int base;

    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    bus.out_ready = 1'b1;
    bus.rd_data = '0;
    for (int i = 0; i < NUM; i++) mem[i] = 32'(i) * 32'h11111111;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // basic dump: 0x33333333..0x66666666, last on the 4th beat
    rdyMode = 0;
    runDump(3, 4);
    waitDone("basic");

    // wrap 30,31,0,1
    runDump(30, 4);
    waitDone("wrap");

    // backpressure on the first beat
    rdyMode = 2;
    bus.out_ready = 1'b0;
    runDump(5, 2);
    waitValid("bp");
    d0 = bus.out_data;
    l0 = bus.out_last;
    chk("bp.first", d0, mem[5]);
    repeat (5) begin
      @(negedge clk);
      chk("bp.data", bus.out_data, d0);
      chk("bp.last", bus.out_last, l0);
      chk("bp.valid", bus.out_valid, 1);
      chk("bp.rdEn", bus.rd_en, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    waitDone("bp");

    // zero count: done one cycle after start is sampled, nothing else
    rdyMode = 0;
    base = doneCnt;
    doneAt = -1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.count = '0;
    bus.start_addr = 5'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done) doneAt = k;
      chk("zero.rdEn", bus.rd_en, 0);
      chk("zero.valid", bus.out_valid, 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("zero.doneAt", doneAt, 1);
    chk("zero.doneCnt", doneCnt - base, 1);

    // second start while busy is ignored
    runDump(10, 3);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.start_addr = 5'd0;
    bus.count = 6'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDone("ignore");

    // reset during HOLD of beat 2
    rdyMode = 2;
    bus.out_ready = 1'b1;
    runDump(0, 4);
    waitValid("rst1");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    waitValid("rst2");
    base = doneCnt;
    #1;
    reset = 1'b0;
    #1;
    checkIdleOutputs("rstMid");
    expAddr.delete();
    expData.delete();
    expLast.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstMid.noDone", doneCnt, base);
    chk("rstMid.idle", bus.busy, 0);
    chk("rstMid.noValid", bus.out_valid, 0);
    rdyMode = 0;
    runDump(7, 1);
    waitDone("rstAfter");

    // parity words 7 and 3
    mem[2] = 32'h7;
    mem[3] = 32'h3;
    runDump(2, 2);
    waitDone("parity");

    // randomized dumps with random backpressure and clamped counts
    rdyMode = 1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NUM; i++) mem[i] = $urandom;
      runDump($urandom_range(0, NUM - 1), $urandom_range(0, 40));
      waitDone("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
